// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared types, defaults and region decode for the CPU memory responder
package cpu_mem_pkg;

  localparam int DEF_ADDR_W = 13;
  localparam int DEF_DATA_W = 8;
  localparam logic [DEF_ADDR_W-1:0] DEF_RAM_BASE = 13'h1800;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    RD_HOLD,
    WR_COMMIT,
    LOAD
  } state_t;

  // Everything at or above base is writable RAM; below it is ROM.
  function automatic logic is_ram(input logic [31:0] addr,
                                  input logic [31:0] base = 32'(DEF_RAM_BASE));
    return addr >= base;
  endfunction

endpackage

// File: rtl/mem_array.sv
// rtl/mem_array.sv - single-port synchronous memory with one write port and a registered read
module mem_array #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Array contents survive reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/cpu_mem_responder.sv
// rtl/cpu_mem_responder.sv - services CPU rd/wr strobes and host preload against a ROM/RAM array
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter logic [ADDR_W-1:0] RAM_BASE = ADDR_W'(DEF_RAM_BASE),
  parameter int                READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rdata_vld,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              busy,
  output logic              err_rom_wr,
  output logic              err_coll,
  input  logic              err_clr
);

  localparam logic [1:0] LAT_INIT = 2'(READ_LAT - 1);

  state_t            state, state_nxt;
  logic              rd_q, wr_q;
  logic [1:0]        cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_start, wr_start, set_coll;
  logic              cap_cpu, cap_ld;
  logic              mem_we, mem_re;
  logic              vld_set, vld_clr, set_rom;

  assign rd_start = cpu_rd & ~rd_q;
  assign wr_start = cpu_wr & ~wr_q;
  assign set_coll = cpu_rd & cpu_wr;
  assign busy     = (state != IDLE);
  // CPU strobes take priority, so the preload port is refused whenever either is high.
  assign ld_ready = (state == IDLE) & ~rst & ~cpu_rd & ~cpu_wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rd_q          <= 1'b0;
      wr_q          <= 1'b0;
      cnt           <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      cpu_rdata_vld <= 1'b0;
      err_rom_wr    <= 1'b0;
      err_coll      <= 1'b0;
    end else begin
      state <= state_nxt;
      rd_q  <= cpu_rd;
      wr_q  <= cpu_wr;
      cnt   <= cnt_nxt;
      if (cap_cpu) begin
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
      end else if (cap_ld) begin
        addr_q  <= ld_addr;
        wdata_q <= ld_data;
      end
      if (vld_set)      cpu_rdata_vld <= 1'b1;
      else if (vld_clr) cpu_rdata_vld <= 1'b0;
      // A new error event in the same cycle as err_clr wins.
      err_rom_wr <= set_rom  | (err_rom_wr & ~err_clr);
      err_coll   <= set_coll | (err_coll & ~err_clr);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    cap_cpu   = 1'b0;
    cap_ld    = 1'b0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    vld_set   = 1'b0;
    vld_clr   = 1'b0;
    set_rom   = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_rd && cpu_wr) begin
          state_nxt = IDLE;
        end else if (rd_start) begin
          cap_cpu   = 1'b1;
          cnt_nxt   = LAT_INIT;
          state_nxt = RD_WAIT;
        end else if (wr_start) begin
          cap_cpu   = 1'b1;
          state_nxt = WR_COMMIT;
        end else if (ld_valid && ld_ready) begin
          cap_ld    = 1'b1;
          state_nxt = LOAD;
        end
      end
      RD_WAIT: begin
        if (!cpu_rd) begin
          state_nxt = IDLE;
        end else if (cnt == 2'd0) begin
          mem_re    = 1'b1;
          vld_set   = 1'b1;
          state_nxt = RD_HOLD;
        end else begin
          cnt_nxt = cnt - 2'd1;
        end
      end
      RD_HOLD: begin
        if (!cpu_rd) begin
          vld_clr   = 1'b1;
          state_nxt = IDLE;
        end
      end
      WR_COMMIT: begin
        if (is_ram(32'(addr_q), 32'(RAM_BASE))) mem_we = 1'b1;
        else                                    set_rom = 1'b1;
        state_nxt = IDLE;
      end
      LOAD: begin
        mem_we    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .we   (mem_we),
    .re   (mem_re),
    .addr (addr_q),
    .wdata(wdata_q),
    .rdata(cpu_rdata)
  );

endmodule

// File: tb/tb_cpu_mem_responder.sv
// tb/tb_cpu_mem_responder.sv - scoreboard bench for cpu_mem_responder at READ_LAT 2 and 4
module tb_cpu_mem_responder;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic        clk = 0;
  logic        rst = 1, b_rst = 1;
  logic        cpu_rd = 0, cpu_wr = 0, ld_valid = 0, err_clr = 0;
  logic [12:0] cpu_addr = 0, ld_addr = 0;
  logic [7:0]  cpu_wdata = 0, ld_data = 0;
  logic [7:0]  cpu_rdata;
  logic        cpu_rdata_vld, ld_ready, busy, err_rom_wr, err_coll;

  logic        b_rd = 0, b_wr = 0;
  logic [12:0] b_addr = 0;
  logic [7:0]  b_wdata = 0, b_rdata;
  logic        b_vld, b_ld_ready, b_busy, b_err_rom, b_err_coll;

  int   cyc = 0;
  int   tests = 0, fails = 0;
  exp_t q_a[$], q_b[$];
  logic vld_prev_a = 0, vld_prev_b = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cpu_mem_responder #(.READ_LAT(2)) dut (
    .clk(clk), .rst(rst), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_rdata_vld(cpu_rdata_vld),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .busy(busy), .err_rom_wr(err_rom_wr), .err_coll(err_coll), .err_clr(err_clr)
  );

  cpu_mem_responder #(.READ_LAT(4)) dut4 (
    .clk(clk), .rst(b_rst), .cpu_rd(b_rd), .cpu_wr(b_wr), .cpu_addr(b_addr),
    .cpu_wdata(b_wdata), .cpu_rdata(b_rdata), .cpu_rdata_vld(b_vld),
    .ld_valid(1'b0), .ld_ready(b_ld_ready), .ld_addr(13'h0), .ld_data(8'h0),
    .busy(b_busy), .err_rom_wr(b_err_rom), .err_coll(b_err_coll), .err_clr(1'b0)
  );

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (cpu_rdata_vld && !vld_prev_a) begin
      if (q_a.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_vld_a: got rdata %0h expected no vld", cpu_rdata);
      end else begin
        e = q_a.pop_front();
        chk("rdata_a", 32'(cpu_rdata), 32'(e.data));
        chk("latency_a", cyc, e.cyc);
      end
    end
    vld_prev_a = cpu_rdata_vld;
  end

  always @(negedge clk) begin
    exp_t e;
    if (b_vld && !vld_prev_b) begin
      if (q_b.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_vld_b: got rdata %0h expected no vld", b_rdata);
      end else begin
        e = q_b.pop_front();
        chk("rdata_b", 32'(b_rdata), 32'(e.data));
        chk("latency_b", cyc, e.cyc);
      end
    end
    vld_prev_b = b_vld;
  end

  task automatic rd_a(input logic [12:0] a, input int hold, input logic [7:0] d);
    exp_t e;
    @(negedge clk);
    cpu_addr = a; cpu_rd = 1;
    e.data = d; e.cyc = cyc + 1 + 2;
    q_a.push_back(e);
    repeat (hold) @(negedge clk);
    chk("vld_before_drop", 32'(cpu_rdata_vld), 1);
    cpu_rd = 0;
    @(negedge clk);
    chk("vld_after_drop", 32'(cpu_rdata_vld), 0);
    chk("busy_after_read", 32'(busy), 0);
  endtask

  task automatic wr_a(input logic [12:0] a, input logic [7:0] d);
    @(negedge clk);
    cpu_addr = a; cpu_wdata = d; cpu_wr = 1;
    repeat (2) @(negedge clk);
    cpu_wr = 0;
    @(negedge clk);
  endtask

  task automatic ld_a(input logic [12:0] a, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    ld_valid = 1; ld_addr = a; ld_data = d;
    while (!ld_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ld_accept", 32'(ld_ready), 1);
    @(negedge clk);
    ld_valid = 0;
    @(negedge clk);
  endtask

  task automatic clr_a();
    @(negedge clk); err_clr = 1;
    @(negedge clk); err_clr = 0;
    chk("err_rom_cleared", 32'(err_rom_wr), 0);
    chk("err_coll_cleared", 32'(err_coll), 0);
  endtask

  task automatic wr_b(input logic [12:0] a, input logic [7:0] d);
    @(negedge clk);
    b_addr = a; b_wdata = d; b_wr = 1;
    repeat (2) @(negedge clk);
    b_wr = 0;
    @(negedge clk);
  endtask

  task automatic rd_b(input logic [12:0] a, input int hold, input logic [7:0] d);
    exp_t e;
    @(negedge clk);
    b_addr = a; b_rd = 1;
    e.data = d; e.cyc = cyc + 1 + 4;
    q_b.push_back(e);
    repeat (hold) @(negedge clk);
    b_rd = 0;
    @(negedge clk);
    chk("b_vld_after_drop", 32'(b_vld), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rdata", 32'(cpu_rdata), 0);
    chk("rst_vld", 32'(cpu_rdata_vld), 0);
    chk("rst_ld_ready", 32'(ld_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_errs", {30'b0, err_rom_wr, err_coll}, 0);
    rst = 0; b_rst = 0;
    @(negedge clk);
    chk("idle_ld_ready", 32'(ld_ready), 1);

    // Test 1: preload then timed read
    ld_a(13'h0005, 8'hA5);
    ld_a(13'h0010, 8'h42);
    ld_a(13'h1801, 8'h77);
    rd_a(13'h0005, 4, 8'hA5);

    // Test 2: RAM write and readback
    wr_a(13'h1800, 8'h3C);
    chk("ram_wr_no_err", 32'(err_rom_wr), 0);
    rd_a(13'h1800, 4, 8'h3C);

    // Test 3: ROM write rejected
    wr_a(13'h0010, 8'hFF);
    chk("rom_wr_err", 32'(err_rom_wr), 1);
    rd_a(13'h0010, 4, 8'h42);
    chk("rom_err_sticky", 32'(err_rom_wr), 1);
    clr_a();

    // Test 4: rd/wr collision
    @(negedge clk);
    cpu_addr = 13'h1801; cpu_wdata = 8'h99; cpu_rd = 1; cpu_wr = 1;
    repeat (3) @(negedge clk);
    chk("coll_err", 32'(err_coll), 1);
    chk("coll_no_vld", 32'(cpu_rdata_vld), 0);
    chk("coll_busy", 32'(busy), 0);
    chk("coll_ld_ready", 32'(ld_ready), 0);
    cpu_rd = 0; cpu_wr = 0;
    @(negedge clk);
    rd_a(13'h1801, 4, 8'h77);
    clr_a();

    // Test 5: preload waits behind an in-flight read
    fork
      rd_a(13'h0005, 5, 8'hA5);
      begin
        repeat (2) @(negedge clk);
        chk("busy_in_read", 32'(busy), 1);
        chk("ld_blocked", 32'(ld_ready), 0);
        ld_a(13'h1900, 8'h5A);
      end
    join
    chk("busy_after_load", 32'(busy), 0);
    rd_a(13'h1900, 4, 8'h5A);

    // Test 6: reset during RD_WAIT at READ_LAT 4
    wr_b(13'h1800, 8'h3C);
    @(negedge clk);
    b_addr = 13'h1800; b_rd = 1;
    repeat (2) @(negedge clk);
    chk("b_busy_in_wait", 32'(b_busy), 1);
    b_rst = 1;
    #1;
    chk("b_rst_vld", 32'(b_vld), 0);
    chk("b_rst_busy", 32'(b_busy), 0);
    chk("b_rst_rdata", 32'(b_rdata), 0);
    chk("b_rst_ld_ready", 32'(b_ld_ready), 0);
    chk("b_rst_errs", {30'b0, b_err_rom, b_err_coll}, 0);
    b_rd = 0;
    repeat (2) @(negedge clk);
    b_rst = 0;
    rd_b(13'h1800, 6, 8'h3C);

    repeat (5) @(negedge clk);
    chk("pending_a", q_a.size(), 0);
    chk("pending_b", q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/cpu_mem_responder.md
Name: cpu_mem_responder

Overview:
- Memory-side responder for the RISC CPU control state machine. It services the controller's rd/wr strobes against an 8 KB unified memory: ROM region 0x0000–0x17FF, RAM region 0x1800–0x1FFF.
- Read latency is programmable. Writes to RAM are committed; writes to ROM are rejected and flagged.
- A host preload port fills memory (program image) while the CPU is idle.
- Sits between the CPU address/data path and the memory array. Replaces the plain combinational ROM/RAM models.

Parameters:
- ADDR_W, 13, address width.
- DATA_W, 8, data width.
- RAM_BASE, 13'h1800, first RAM address; addresses below it are ROM.
- READ_LAT, 2, cycles from sampled rd rising edge to valid read data; legal range 1..4.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous reset, active-high.
- cpu_rd  in  1  read strobe from CPU controller; held high ≥ READ_LAT+1 cycles per access.
- cpu_wr  in  1  write strobe from CPU controller.
- cpu_addr  in  ADDR_W  access address; stable while cpu_rd or cpu_wr is high.
- cpu_wdata  in  DATA_W  write data; valid while cpu_wr is high.
- cpu_rdata  out  DATA_W  read data, registered.
- cpu_rdata_vld  out  1  cpu_rdata is valid for the current read.
- ld_valid  in  1  preload request.
- ld_ready  out  1  preload accept; transfer occurs when ld_valid & ld_ready.
- ld_addr  in  ADDR_W  preload address.
- ld_data  in  DATA_W  preload data.
- busy  out  1  high in any state other than IDLE.
- err_rom_wr  out  1  sticky: CPU write to ROM region attempted.
- err_coll  out  1  sticky: cpu_rd and cpu_wr sampled high together.
- err_clr  in  1  synchronous clear of both sticky flags.

Behaviour:
- Reset: state=IDLE, counters=0, and cpu_rdata=0, cpu_rdata_vld=0, ld_ready=0, busy=0, err_rom_wr=0, err_coll=0. Memory contents are not reset.
- Reset mid-operation aborts the access immediately. A write not yet committed is dropped. Outputs return to reset values.
- Edge detect: rd_q and wr_q are registered copies of cpu_rd and cpu_wr. A start condition is the strobe high with its _q low.
- States: IDLE, RD_WAIT, RD_HOLD, WR_COMMIT, LOAD.
- IDLE:
  - rd rise and cpu_wr low → capture address, load latency counter = READ_LAT-1, go to RD_WAIT.
  - wr rise and cpu_rd low → go to WR_COMMIT.
  - cpu_rd & cpu_wr both high → set err_coll, stay in IDLE, no memory action.
  - Otherwise ld_ready=1. A preload handshake → go to LOAD.
- RD_WAIT: decrement the counter each cycle. When the counter hits 0, register mem[addr] into cpu_rdata, set cpu_rdata_vld=1, go to RD_HOLD. Data is valid exactly READ_LAT cycles after the edge where the rd rise was sampled.
- RD_HOLD: cpu_rdata_vld stays 1 while cpu_rd is high. When cpu_rd is sampled low, clear vld next cycle and go to IDLE. cpu_rdata keeps its last value.
- cpu_rd dropping during RD_WAIT aborts the read: no vld pulse, go to IDLE.
- WR_COMMIT (one cycle):
  - addr ≥ RAM_BASE → mem[addr]=cpu_wdata.
  - Otherwise no write; set err_rom_wr.
  - Go to IDLE. A new write requires a fresh wr rise.
- LOAD (one cycle): mem[ld_addr]=ld_data; writes any region, including ROM. ld_ready=0; go to IDLE.
- Priority in IDLE: CPU rd/wr over preload. ld_ready is combinationally low when cpu_rd or cpu_wr is high.
- err_clr: clears both sticky flags. If an error event occurs in the same cycle, the set wins.
- Address wrap: none. Full ADDR_W space is decoded, so there are no out-of-range addresses.

Decomposition:
- Package cpu_mem_pkg holds:
  - state enum: IDLE, RD_WAIT, RD_HOLD, WR_COMMIT, LOAD.
  - ADDR_W and DATA_W defaults.
  - RAM_BASE.
  - function is_ram(addr).
- One sub-module, mem_array: single-port synchronous RAM, 2^ADDR_W × DATA_W, one write port and registered read. The responder muxes CPU and preload accesses onto it.

Test Plan:
1. Preload 0x0005=0xA5 via ld port, then CPU rd at 0x0005 held 4 cycles, READ_LAT=2 → cpu_rdata=0xA5 and vld=1 exactly 2 cycles after the rd rise; vld falls 1 cycle after rd falls.
2. CPU wr 0x1800 with 0x3C, then rd 0x1800 → rdata=0x3C, err_rom_wr=0.
3. CPU wr 0x0010 with 0xFF (ROM) → mem[0x0010] unchanged on readback; err_rom_wr=1 until err_clr pulse, then 0.
4. cpu_rd and cpu_wr raised in the same cycle at 0x1801 → err_coll=1, mem[0x1801] unchanged, no vld pulse.
5. ld_valid held high while a CPU read is in progress → ld_ready=0 until IDLE; load completes afterwards; busy tracks non-IDLE.
6. Assert rst during RD_WAIT with READ_LAT=4 → vld never asserts, all outputs 0; memory contents from test 2 are preserved on a post-reset read.
